// File: rtl/iterative_multiplier.sv
// rtl/iterative_multiplier.sv - radix-2 iterative 64x64 multiplier (MUL / UMULH / SMULH)
//
// Ports:
//   Clk, Reset           clock and synchronous active-high reset
//   Start, Op, A, B, Rd  request, opcode (00 MUL, 01 UMULH, 10 SMULH, 11 reserved), operands, destination
//   Busy                 high while shift-add steps are running
//   Done                 one-cycle completion pulse; Result/RW/RegWr valid while high
//   Result, RW, RegWr    register-file write port (BusW, RW, RegWr); RegWr suppressed for Rd=31
//
// Optional build macro: MUL_EARLY_TERM_EN
//   When defined, the run ends as soon as the remaining multiplier bits are all zero.

module iterative_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Rd,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       RW,
    output logic             RegWr
);

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [1:0]    OP_MUL    = 2'b00;
    localparam logic [1:0]    OP_SMULH  = 2'b10;
    localparam logic [1:0]    OP_RSVD   = 2'b11;
    localparam logic [4:0]    XZR       = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateType;

    stateType state;
    stateType nextState;

    logic                 accept;
    logic                 lastStep;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   stepAcc;
    logic [2*WIDTH-1:0]   signedProduct;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [CW-1:0]        stepCount;
    logic [1:0]           opReg;
    logic [4:0]           rdReg;
    logic                 negReg;

    // Requests are only looked at when no run is in flight.
    assign accept = Start && (Op != OP_RSVD) && ((state == IDLE) || (state == DONE));

    // Magnitudes for SMULH; the most negative value maps onto itself, which is
    // the correct unsigned magnitude 2^(WIDTH-1).
    assign magA = A[WIDTH-1] ? (-A) : A;
    assign magB = B[WIDTH-1] ? (-B) : B;

    // Accumulator value after the current step, including the final one.
    assign stepAcc       = mplier[0] ? (acc + mcand) : acc;
    assign signedProduct = negReg ? (-stepAcc) : stepAcc;

`ifdef MUL_EARLY_TERM_EN
    // Stop once the multiplier bits still to be consumed are all zero.
    assign lastStep = ((mplier >> 1) == '0) || (stepCount == LAST_STEP);
`else
    assign lastStep = (stepCount == LAST_STEP);
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = RUN;
            RUN:     if (lastStep) nextState = DONE;
            DONE:    nextState = accept ? RUN : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy  = (state == RUN);
        Done  = (state == DONE);
        RegWr = (state == DONE) && (RW != XZR);
    end

    // Datapath: operand latch, shift-add steps, result capture.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            stepCount <= '0;
            opReg     <= '0;
            rdReg     <= '0;
            negReg    <= 1'b0;
            Result    <= '0;
            RW        <= '0;
        end else if (accept) begin
            acc       <= '0;
            stepCount <= '0;
            opReg     <= Op;
            rdReg     <= Rd;
            if (Op == OP_SMULH) begin
                mcand  <= {{WIDTH{1'b0}}, magA};
                mplier <= magB;
                negReg <= A[WIDTH-1] ^ B[WIDTH-1];
            end else begin
                mcand  <= {{WIDTH{1'b0}}, A};
                mplier <= B;
                negReg <= 1'b0;
            end
        end else if (state == RUN) begin
            acc       <= stepAcc;
            mcand     <= mcand << 1;
            mplier    <= mplier >> 1;
            stepCount <= stepCount + 1'b1;
            if (lastStep) begin
                Result <= (opReg == OP_MUL) ? signedProduct[WIDTH-1:0]
                                            : signedProduct[2*WIDTH-1:WIDTH];
                RW     <= rdReg;
            end
        end
    end

endmodule

// File: tb/tb_iterative_multiplier.sv
// tb/tb_iterative_multiplier.sv - self-checking bench for iterative_multiplier

module tb_iterative_multiplier;

`ifdef MUL_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [63:0] A;
    logic [63:0] B;
    logic [4:0]  Rd;
    logic        Busy;
    logic        Done;
    logic [63:0] Result;
    logic [4:0]  RW;
    logic        RegWr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int startCyc = 0;
    bit checkEn = 1'b0;

    // Reference model state
    bit          mBusy = 1'b0;
    bit          mDone = 1'b0;
    logic [63:0] mResult = '0;
    logic [4:0]  mRW = '0;
    logic [63:0] pendResult = '0;
    logic [4:0]  pendRd = '0;
    int          remaining = 0;

    iterative_multiplier #(.WIDTH(64)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B), .Rd(Rd),
        .Busy(Busy), .Done(Done), .Result(Result), .RW(RW), .RegWr(RegWr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [63:0] refResult(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [127:0] sa;
        logic [127:0] sb;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        if (op == 2'b10) p = $signed(sa) * $signed(sb);
        else             p = {64'b0, a} * {64'b0, b};
        return (op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic int refSteps(input logic [1:0] op, input logic [63:0] b);
        logic [63:0] m;
        int msb;
        m = (op == 2'b10 && b[63]) ? -b : b;
        msb = -1;
        for (int i = 0; i < 64; i++) if (m[i]) msb = i;
        if (!ET) return 64;
        return (msb + 1 < 1) ? 1 : msb + 1;
    endfunction

    // Behavioural model: a countdown of remaining RUN cycles per accepted op.
    always @(posedge Clk) begin
        bit newDone;
        newDone = 1'b0;
        if (Reset) begin
            mBusy = 1'b0;
            mResult = '0;
            mRW = '0;
            remaining = 0;
        end else if (mBusy) begin
            remaining = remaining - 1;
            if (remaining == 0) begin
                mBusy = 1'b0;
                newDone = 1'b1;
                mResult = pendResult;
                mRW = pendRd;
            end
        end else if (Start && Op != 2'b11) begin
            mBusy = 1'b1;
            remaining = refSteps(Op, B);
            pendResult = refResult(Op, A, B);
            pendRd = Rd;
        end
        mDone = newDone;
    end

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (checkEn) begin
            checkVal("cmp_busy",   64'(Busy),   64'(mBusy));
            checkVal("cmp_done",   64'(Done),   64'(mDone));
            checkVal("cmp_regwr",  64'(RegWr),  64'(mDone && mRW != 5'd31));
            checkVal("cmp_rw",     64'(RW),     64'(mRW));
            checkVal("cmp_result", Result,      mResult);
        end
    end

    // Drives a request at the current time; returns at the negedge after the sampling edge.
    task automatic issueStart(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        Start = 1'b1; Op = op; A = a; B = b; Rd = rd;
        @(posedge Clk); #2;
        Start = 1'b0; A = ~a; B = ~b; Rd = ~rd;
        @(negedge Clk);
        startCyc = cyc;
    endtask

    task automatic waitDone(input string name, input int expLat, input logic [63:0] expRes,
                            input logic [4:0] expRw, input logic expRegWr);
        int n;
        n = 0;
        while (!Done && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!Done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no Done expected Done within 200 cycles", name);
        end else begin
            checkVal({name, "_latency"}, 64'(cyc - startCyc + 1), 64'(expLat));
            checkVal({name, "_result"}, Result, expRes);
            checkVal({name, "_rw"}, 64'(RW), 64'(expRw));
            checkVal({name, "_regwr"}, 64'(RegWr), 64'(expRegWr));
        end
    endtask

    initial begin
        int doneSeen;
        Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0; Rd = '0;
        @(posedge Clk);
        checkEn = 1'b1;
        @(posedge Clk); #2;
        Reset = 1'b0;
        @(negedge Clk);
        checkVal("reset_busy", 64'(Busy), 64'd0);
        checkVal("reset_done", 64'(Done), 64'd0);
        checkVal("reset_regwr", 64'(RegWr), 64'd0);
        checkVal("reset_result", Result, 64'd0);
        checkVal("reset_rw", 64'(RW), 64'd0);

        issueStart(2'b00, 64'd3, 64'd5, 5'd2);
        waitDone("mul_3x5", ET ? 4 : 65, 64'd15, 5'd2, 1'b1);
        @(negedge Clk);
        checkVal("done_one_cycle", 64'(Done), 64'd0);
        checkVal("result_hold", Result, 64'd15);

        issueStart(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3);
        waitDone("umulh_ones", 65, 64'hFFFF_FFFF_FFFF_FFFE, 5'd3, 1'b1);
        @(negedge Clk);
        issueStart(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4);
        waitDone("mul_ones", 65, 64'h0000_0000_0000_0001, 5'd4, 1'b1);
        @(negedge Clk);
        issueStart(2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd5);
        waitDone("smulh_m2x3", ET ? 3 : 65, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b1);
        @(negedge Clk);
        issueStart(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6);
        waitDone("smulh_corner", ET ? 2 : 65, 64'h0, 5'd6, 1'b1);
        @(negedge Clk);
        issueStart(2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 5'd7);
        waitDone("smulh_maxmin", 65, 64'hC000_0000_0000_0000, 5'd7, 1'b1);

        // Reserved opcode is ignored.
        @(negedge Clk);
        Start = 1'b1; Op = 2'b11; A = 64'd9; B = 64'd9;
        @(negedge Clk);
        Start = 1'b0;
        checkVal("rsvd_busy", 64'(Busy), 64'd0);
        checkVal("rsvd_done", 64'(Done), 64'd0);

        // Start while running is ignored; then back-to-back from the DONE cycle.
        issueStart(2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3);
        repeat (9) @(negedge Clk);
        Start = 1'b1; Op = 2'b00; A = 64'd2; B = 64'd2; Rd = 5'd4;
        @(negedge Clk);
        Start = 1'b0;
        waitDone("ignore_in_run", 65, 64'hFFFF_FFFF_FFFF_FFF9, 5'd3, 1'b1);
        issueStart(2'b00, 64'd2, 64'd3, 5'd4);
        checkVal("b2b_busy", 64'(Busy), 64'd1);
        waitDone("b2b_second", ET ? 3 : 65, 64'd6, 5'd4, 1'b1);

        // Reset 30 cycles into a run aborts it.
        @(negedge Clk);
        issueStart(2'b00, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5);
        repeat (29) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checkVal("abort_busy", 64'(Busy), 64'd0);
        checkVal("abort_done", 64'(Done), 64'd0);
        checkVal("abort_regwr", 64'(RegWr), 64'd0);
        checkVal("abort_result", Result, 64'd0);
        checkVal("abort_rw", 64'(RW), 64'd0);
        doneSeen = 0;
        repeat (80) begin
            @(negedge Clk);
            if (Done || RegWr) doneSeen++;
        end
        checkVal("abort_no_done", 64'(doneSeen), 64'd0);

        // XZR destination: Done pulses, no write.
        issueStart(2'b00, 64'd4, 64'd4, 5'd31);
        waitDone("xzr", ET ? 4 : 65, 64'd16, 5'd31, 1'b0);

        // Early-termination latencies (fixed 65 in the default build).
        @(negedge Clk);
        issueStart(2'b00, 64'd7, 64'd5, 5'd8);
        waitDone("mul_7x5", ET ? 4 : 65, 64'd35, 5'd8, 1'b1);
        @(negedge Clk);
        issueStart(2'b00, 64'd7, 64'd0, 5'd9);
        waitDone("mul_7x0", ET ? 2 : 65, 64'd0, 5'd9, 1'b1);

        repeat (3) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
